// File: rtl/sram_pkg.sv
// Shared types and defaults for the CY6264 8Kx8 asynchronous SRAM initiator.
// Holds the FSM state encoding, the part geometry and the default strobe timing.
package sram_pkg;

   localparam int CY_AW       = 13;
   localparam int CY_DW       = 8;
   localparam int DEF_WR_WAIT = 2;
   localparam int DEF_RD_WAIT = 2;
   localparam int DEF_TURN    = 1;
   localparam int CTR_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_RD_WAIT,
      S_RD_TURN
   } state_t;

   // A phase of N clocks loads N-1; the phase ends on the clock the counter reads zero.
   function automatic logic [CTR_W-1:0] wait_load(input int clks);
      return CTR_W'(clks - 1);
   endfunction

endpackage

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter timing the write pulse, read wait and turnaround phases.
// Load has priority over decrement; the count saturates at zero.
module sram_wait_ctr
   import sram_pkg::*;
#(
   parameter int W = CTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_cy6264.sv
// Single-outstanding valid/ready initiator driving the CY6264 pins with registered,
// glitch-free strobes and a registered io drive enable.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | chip deselected, ready for a request, addr holds last value
//   S_SETUP    | addr valid, chip selected, strobes high; write drives io
//   S_WR_PULSE | we_n low for WR_WAIT clocks with write data on io
//   S_WR_HOLD  | we_n high, addr/io held one clock past the WE# rise
//   S_RD_WAIT  | oe_n low for RD_WAIT clocks; io sampled at the final edge
//   S_RD_TURN  | chip deselected, io released for TURN clocks
module sram_ctrl_cy6264
   import sram_pkg::*;
#(
   parameter int AW      = CY_AW,
   parameter int DW      = CY_DW,
   parameter int WR_WAIT = DEF_WR_WAIT,
   parameter int RD_WAIT = DEF_RD_WAIT,
   parameter int TURN    = DEF_TURN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic [AW-1:0] sram_addr,
   inout  wire  [DW-1:0] sram_io,
   output logic          sram_ce1_n,
   output logic          sram_ce2,
   output logic          sram_we_n,
   output logic          sram_oe_n
);

   state_t            state;
   logic              we_q;
   logic [DW-1:0]     wdata_q;
   logic              io_oe;
   logic              ctr_load;
   logic              ctr_dec;
   logic              ctr_zero;
   logic [CTR_W-1:0]  ctr_val;

   assign req_ready = (state == S_IDLE) && !rst;
   assign sram_io   = io_oe ? wdata_q : {DW{1'bz}};

   sram_wait_ctr #(.W(CTR_W)) u_wait_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (ctr_dec),
      .zero     (ctr_zero)
   );

   // The counter is armed on the clock before each timed phase starts.
   always_comb begin
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      ctr_val  = '0;
      case (state)
         S_SETUP: begin
            ctr_load = 1'b1;
            ctr_val  = we_q ? wait_load(WR_WAIT) : wait_load(RD_WAIT);
         end
         S_WR_PULSE, S_RD_TURN: begin
            ctr_dec = !ctr_zero;
         end
         S_RD_WAIT: begin
            if (ctr_zero) begin
               ctr_load = 1'b1;
               ctr_val  = wait_load(TURN);
            end else begin
               ctr_dec = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         io_oe      <= 1'b0;
         sram_addr  <= '0;
         sram_ce1_n <= 1'b1;
         sram_ce2   <= 1'b0;
         sram_we_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  wdata_q    <= req_wdata;
                  sram_addr  <= req_addr;
                  io_oe      <= req_we;
                  sram_ce1_n <= 1'b0;
                  sram_ce2   <= 1'b1;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (we_q) begin
                  sram_we_n <= 1'b0;
                  state     <= S_WR_PULSE;
               end else begin
                  sram_oe_n <= 1'b0;
                  state     <= S_RD_WAIT;
               end
            end
            S_WR_PULSE: begin
               if (ctr_zero) begin
                  sram_we_n <= 1'b1;
                  state     <= S_WR_HOLD;
               end
            end
            S_WR_HOLD: begin
               io_oe      <= 1'b0;
               sram_ce1_n <= 1'b1;
               sram_ce2   <= 1'b0;
               state      <= S_IDLE;
            end
            S_RD_WAIT: begin
               if (ctr_zero) begin
                  rsp_rdata  <= sram_io;
                  rsp_valid  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  sram_ce1_n <= 1'b1;
                  sram_ce2   <= 1'b0;
                  state      <= S_RD_TURN;
               end
            end
            S_RD_TURN: begin
               if (ctr_zero) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
